// File: rtl/prog_loader_if.sv
// Byte stream in and RAM write port out of the program loader.
// master = host/RAM side, slave = loader.
interface prog_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  ram_we,
        input  ram_addr,
        input  ram_wdata
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output ram_we,
        output ram_addr,
        output ram_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Streams a header + payload into program RAM while holding the CPU.
// Define PROG_LOADER_CHECKSUM_EN to add a trailing checksum byte and err.
module prog_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    prog_loader_if.slave     bus,
    output logic             cpu_hold,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] count
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HDR  = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic [2:0] CSUM = 3'd3;
`endif
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2 ** ADDR_W);

    logic [2:0]        state;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] remain;
    logic              busy;
    logic              accept;
    logic              idle_like;

`ifdef PROG_LOADER_CHECKSUM_EN
    assign busy = (state == HDR) || (state == DATA) || (state == CSUM);
`else
    assign busy = (state == HDR) || (state == DATA);
`endif

    assign idle_like = (state == IDLE) || (state == DONE);
    assign accept    = bus.in_valid && busy;

    assign bus.in_ready  = busy;
    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;

    // Hold covers the final write pulse, which lands after DONE is entered.
    assign cpu_hold = busy || we_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            next_addr <= '0;
            remain    <= '0;
            count     <= '0;
            done      <= 1'b0;
        end else begin
            we_q <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= HDR;
                        done  <= 1'b0;
                        count <= '0;
                    end
                end
                HDR: begin
                    if (accept) begin
                        next_addr <= bus.in_data[2*ADDR_W-1:ADDR_W];
                        remain    <= bus.in_data[ADDR_W-1:0];
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        we_q      <= 1'b1;
                        addr_q    <= next_addr;
                        wdata_q   <= bus.in_data;
                        next_addr <= next_addr + 1'b1;
                        if (count != CNT_MAX) begin
                            count <= count + 1'b1;
                        end
                        if (remain == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state <= CSUM;
`else
                            state <= DONE;
                            done  <= 1'b1;
`endif
                        end else begin
                            remain <= remain - 1'b1;
                        end
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (accept) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] sum_chk;
    logic              err_q;

    assign sum_chk = sum + bus.in_data;
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum   <= '0;
            err_q <= 1'b0;
        end else if (idle_like && start) begin
            sum   <= '0;
            err_q <= 1'b0;
        end else if (accept && state == DATA) begin
            sum <= sum_chk;
        end else if (accept && state == CSUM) begin
            err_q <= (sum_chk != '0);
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a write scoreboard.
// Builds with or without PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;
    logic       clk;
    logic       reset;
    logic       start;
    logic       cpu_hold;
    logic       done;
    logic       err;
    logic [4:0] count;

    int total = 0;
    int bad   = 0;
    int wr_pulses = 0;

    logic [11:0] sb[$];
    logic [3:0]  exp_addr;
    logic [7:0]  tsum;

    prog_loader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    prog_loader #(.ADDR_W(4), .DATA_W(8), .CNT_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every write pulse must match the oldest expected (addr, data).
    always @(negedge clk) begin
        if (bus.ram_we === 1'b1) begin
            logic [11:0] e;
            total++;
            wr_pulses++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexp_write got=%h_%h want=none",
                       bus.ram_addr, bus.ram_wdata);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                assert ({bus.ram_addr, bus.ram_wdata} === e) else begin
                    bad++;
                    $error("FAIL write got=%h_%h want=%h_%h",
                           bus.ram_addr, bus.ram_wdata, e[11:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit pay);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(bus.in_ready), 32'd1);
        if (pay) begin
            sb.push_back({exp_addr, b});
            exp_addr = exp_addr + 4'd1;
            tsum     = tsum + b;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic hdr(input logic [7:0] h);
        send(h, 1'b0);
        exp_addr = h[7:4];
    endtask

    task automatic start_load();
        @(negedge clk);
        start = 1'b1;
        tsum  = 8'h00;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_load();
        int n;
`ifdef PROG_LOADER_CHECKSUM_EN
        send(8'(8'h00 - tsum), 1'b0);
`endif
        n = 0;
        @(negedge clk);
        while (cpu_hold !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_release", 32'(cpu_hold), 32'd0);
        chk("done_set", 32'(done), 32'd1);
    endtask

    initial begin
        int p0;
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        exp_addr     = 4'h0;
        tsum         = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_we", 32'(bus.ram_we), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_wdata", 32'(bus.ram_wdata), 32'd0);
        reset = 1'b0;

        // basic load at address 2
        start_load();
        hdr(8'h22);
        send(8'hA1, 1'b1);
        send(8'hB2, 1'b1);
        send(8'hC3, 1'b1);
`ifndef PROG_LOADER_CHECKSUM_EN
        @(negedge clk);
        chk("t1_pulse_we", 32'(bus.ram_we), 32'd1);
        chk("t1_pulse_hold", 32'(cpu_hold), 32'd1);
        chk("t1_pulse_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("t1_after_hold", 32'(cpu_hold), 32'd0);
        chk("t1_after_we", 32'(bus.ram_we), 32'd0);
`endif
        finish_load();
        chk("t1_count", 32'(count), 32'd3);

        // wrap from F to 0
        start_load();
        hdr(8'hE3);
        for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 1'b1);
        finish_load();
        chk("t2_count", 32'(count), 32'd4);

        // valid gap between payload bytes
        p0 = wr_pulses;
        start_load();
        hdr(8'h01);
        send(8'h55, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("t3_gap_ready", 32'(bus.in_ready), 32'd1);
            chk("t3_gap_hold", 32'(cpu_hold), 32'd1);
        end
        send(8'h66, 1'b1);
        finish_load();
        chk("t3_pulses", 32'(wr_pulses - p0), 32'd2);

        // reset in the middle of a load
        start_load();
        hdr(8'h05);
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_ready", 32'(bus.in_ready), 32'd0);
        chk("t4_we", 32'(bus.ram_we), 32'd0);
        chk("t4_hold", 32'(cpu_hold), 32'd0);
        chk("t4_count", 32'(count), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
        reset = 1'b0;
        p0 = wr_pulses;
        bus.in_data  = 8'h99;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t4_idle_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t4_no_write", 32'(wr_pulses - p0), 32'd0);

        // start during DATA is ignored
        start_load();
        hdr(8'h41);
        send(8'h77, 1'b1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_still_ready", 32'(bus.in_ready), 32'd1);
        send(8'h88, 1'b1);
        finish_load();
        chk("t5_count", 32'(count), 32'd2);
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("t5_done_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;

        // full 16-byte load
        start_load();
        chk("t16_count_clr", 32'(count), 32'd0);
        chk("t16_done_clr", 32'(done), 32'd0);
        hdr(8'h8F);
        for (int i = 0; i < 16; i++) send(8'(8'hC0 + i), 1'b1);
        finish_load();
        chk("t16_count", 32'(count), 32'd16);

`ifdef PROG_LOADER_CHECKSUM_EN
        start_load();
        hdr(8'h02);
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        send(8'h03, 1'b1);
        send(8'hFA, 1'b0);
        @(negedge clk);
        chk("t6_good_done", 32'(done), 32'd1);
        chk("t6_good_err", 32'(err), 32'd0);

        start_load();
        hdr(8'h02);
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        send(8'h03, 1'b1);
        send(8'hFB, 1'b0);
        @(negedge clk);
        chk("t6_bad_done", 32'(done), 32'd1);
        chk("t6_bad_err", 32'(err), 32'd1);

        start_load();
        chk("t6_err_clr", 32'(err), 32'd0);
        hdr(8'h00);
        send(8'h5A, 1'b1);
        finish_load();
        chk("t6_err_after", 32'(err), 32'd0);
`endif

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
